// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART TX core between byte-stream requesters
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int LOCK_EN      = 1,
    parameter int LOCK_TIMEOUT = 16,
    parameter int BUSY_TIMEOUT = 8,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      grant_active,
    output logic                      err_timeout
);

    localparam int BUSY_W = $clog2(BUSY_TIMEOUT + 1);
    localparam int LOCK_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_IDLE,
        S_LOCKED
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic              last_q;
    logic [BUSY_W-1:0] busy_cnt;
    logic [LOCK_W-1:0] lock_cnt;

    logic [DATA_W-1:0]  data_arr [NUM_REQ];
    logic               any_valid;
    logic [ID_W-1:0]    rr_winner;
    logic [NUM_REQ-1:0] win_onehot;
    logic [NUM_REQ-1:0] own_onehot;

    // First requester with valid set, searching upward from the slot after rr_ptr
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                input logic [ID_W-1:0]    ptr);
        logic            found;
        logic [ID_W-1:0] sel;
        logic [ID_W-1:0] pick;
        int              idx;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            sel = ID_W'(idx);
            if (!found && v[sel]) begin
                found = 1'b1;
                pick  = sel;
            end
        end
        return pick;
    endfunction

    // Unpack the flat requester data bus into one byte per requester
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign any_valid  = |req_valid;
    assign rr_winner  = rr_pick(req_valid, rr_ptr);
    assign win_onehot = ONE_HOT0 << rr_winner;
    assign own_onehot = ONE_HOT0 << grant_id;

    // Arbitration and TX handshake sequencer; every output is a register of this block
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            req_ready    <= '0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            err_timeout  <= 1'b0;
            rr_ptr       <= ID_W'(NUM_REQ - 1);
            last_q       <= 1'b0;
            busy_cnt     <= '0;
            lock_cnt     <= '0;
        end else begin
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A frame still on the wire (ours or foreign) blocks new grants
                    if (any_valid && !tx_busy) begin
                        grant_id     <= rr_winner;
                        grant_active <= 1'b1;
                        req_ready    <= win_onehot;
                        state        <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    req_ready <= '0;
                    if (req_valid[grant_id]) begin
                        tx_data  <= data_arr[grant_id];
                        last_q   <= req_last[grant_id];
                        tx_start <= 1'b1;
                        state    <= S_START;
                    end else begin
                        // Requester withdrew its byte: drop the grant without sending
                        rr_ptr       <= grant_id;
                        grant_active <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                S_START: begin
                    // The start-pulse cycle counts as the first cycle of the busy wait
                    busy_cnt <= BUSY_W'(1);
                    state    <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= S_WAIT_IDLE;
                    end else if (busy_cnt >= BUSY_W'(BUSY_TIMEOUT - 1)) begin
                        err_timeout  <= 1'b1;
                        rr_ptr       <= grant_id;
                        grant_active <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (!tx_busy) begin
                        if ((LOCK_EN != 0) && !last_q) begin
                            // The cycle busy fell is the first cycle of the lock wait
                            lock_cnt <= LOCK_W'(1);
                            state    <= S_LOCKED;
                        end else begin
                            rr_ptr       <= grant_id;
                            grant_active <= 1'b0;
                            state        <= S_IDLE;
                        end
                    end
                end
                S_LOCKED: begin
                    if (req_valid[grant_id]) begin
                        req_ready <= own_onehot;
                        state     <= S_GRANT;
                    end else if (lock_cnt >= LOCK_W'(LOCK_TIMEOUT - 1)) begin
                        rr_ptr       <= grant_id;
                        grant_active <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: begin
                    req_ready    <= '0;
                    grant_active <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [DW-1:0]   tx_data;
    logic            tx_start;
    logic            tx_busy;
    logic [1:0]      grant_id;
    logic            grant_active;
    logic            err_timeout;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .DATA_W       (DW),
        .LOCK_EN      (1),
        .LOCK_TIMEOUT (16),
        .BUSY_TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .grant_id     (grant_id),
        .grant_active (grant_active),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    // TX core model: busy rises the cycle after tx_start and stays up tx_len cycles
    int   tx_len  = 20;
    logic tx_mute = 1'b0;
    int   tx_cnt;
    always @(posedge clk) begin
        if (!rst) begin
            tx_busy <= 1'b0;
            tx_cnt  <= 0;
        end else if (tx_start && !tx_mute) begin
            tx_busy <= 1'b1;
            tx_cnt  <= tx_len - 1;
        end else if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
        end else begin
            tx_busy <= 1'b0;
        end
    end

    // Requester byte queues
    logic [8:0] pkt  [NR][16];
    logic [3:0] head [NR];
    logic [3:0] tail [NR];
    logic       took [NR];

    // Monitors
    int         cyc = 0;
    logic [7:0] log_data [$];
    logic [1:0] log_id   [$];
    int         log_cyc  [$];
    int         err_cnt = 0;
    int         err_cyc = 0;
    int         busy_fall_cyc = 0;
    int         ga_fall_cyc = 0;
    int         onehot_bad = 0;
    logic       prev_busy = 1'b0;
    logic       prev_ga = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] fair_exp [8] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10, 8'h21, 8'h32, 8'h43};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] log_d(input int k);
        if (k < log_data.size()) return 32'(log_data[k]);
        return 32'hDEAD;
    endfunction

    function automatic logic [31:0] log_i(input int k);
        if (k < log_id.size()) return 32'(log_id[k]);
        return 32'hDEAD;
    endfunction

    function automatic int log_c(input int k);
        if (k < log_cyc.size()) return log_cyc[k];
        return -1000;
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (head[i] < tail[i]) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = pkt[i][head[i]][7:0];
                req_last[i]           = pkt[i][head[i]][8];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
                req_last[i]           = 1'b0;
            end
        end
    endtask

    task automatic push(input int r, input logic last, input logic [7:0] d);
        pkt[r][tail[r]] = {last, d};
        tail[r] = tail[r] + 4'd1;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) begin
            head[i] = '0;
            tail[i] = '0;
            took[i] = 1'b0;
        end
        drive();
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_id.delete();
        log_cyc.delete();
        err_cnt = 0;
    endtask

    // One clock: edge, then sample at the falling edge and advance requesters
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (tx_start) begin
            log_data.push_back(tx_data);
            log_id.push_back(grant_id);
            log_cyc.push_back(cyc);
        end
        if (err_timeout) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (!$onehot0(req_ready)) onehot_bad++;
        if (prev_busy && !tx_busy) busy_fall_cyc = cyc;
        if (prev_ga && !grant_active) ga_fall_cyc = cyc;
        prev_busy = tx_busy;
        prev_ga   = grant_active;
        for (int i = 0; i < NR; i++) begin
            if (took[i]) head[i] = head[i] + 4'd1;
        end
        drive();
        for (int i = 0; i < NR; i++) took[i] = req_valid[i] && req_ready[i];
    endtask

    task automatic wait_log(input string tag, input int n, input int budget);
        int b;
        b = budget;
        while (log_data.size() < n && b > 0) begin
            tick();
            b--;
        end
        check(tag, 32'(log_data.size() >= n), 32'h1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_reqs();
        tick();
        rst = 1'b1;
        clear_logs();
        tick();
    endtask

    int v_cyc;
    int b;
    int rep_bad;

    initial begin
        rst = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        clear_reqs();
        tick();
        tick();
        check("rst_ready",  32'(req_ready),    32'h0);
        check("rst_start",  32'(tx_start),     32'h0);
        check("rst_data",   32'(tx_data),      32'h0);
        check("rst_gid",    32'(grant_id),     32'h0);
        check("rst_gact",   32'(grant_active), 32'h0);
        check("rst_err",    32'(err_timeout),  32'h0);
        rst = 1'b1;
        tick();

        // Single byte from req0 with a long frame
        tx_len = 2330;
        push(0, 1'b1, 8'h55);
        drive();
        v_cyc = cyc;
        tick();
        check("t1_ready",   32'(req_ready),    32'h1);
        check("t1_gid",     32'(grant_id),     32'h0);
        check("t1_gact",    32'(grant_active), 32'h1);
        tick();
        check("t1_start",   32'(tx_start),     32'h1);
        check("t1_data",    32'(tx_data),      32'h55);
        check("t1_ready0",  32'(req_ready),    32'h0);
        check("t1_latency", 32'(cyc - v_cyc),  32'd2);
        b = 3000;
        while (grant_active && b > 0) begin
            tick();
            b--;
        end
        check("t1_gact_low", 32'(grant_active), 32'h0);
        check("t1_release",  32'(ga_fall_cyc - busy_fall_cyc), 32'd1);
        tx_len = 20;
        push(0, 1'b1, 8'h11);
        push(1, 1'b1, 8'h22);
        drive();
        wait_log("t1_rr_wait", 3, 200);
        check("t1_rr_id1",  log_i(1), 32'h1);
        check("t1_rr_d1",   log_d(1), 32'h22);
        check("t1_rr_id2",  log_i(2), 32'h0);

        // Fairness across four single-byte requesters
        do_reset();
        for (int r = 0; r < 2; r++) begin
            push(0, 1'b1, 8'h10);
            push(1, 1'b1, 8'h21);
            push(2, 1'b1, 8'h32);
            push(3, 1'b1, 8'h43);
        end
        drive();
        wait_log("fair_wait", 8, 600);
        for (int k = 0; k < 5; k++) check($sformatf("fair_d%0d", k), log_d(k), 32'(fair_exp[k]));
        rep_bad = 0;
        for (int k = 1; k < log_id.size(); k++) if (log_id[k] == log_id[k-1]) rep_bad++;
        check("fair_norepeat", 32'(rep_bad), 32'h0);

        // Packet lock: req1 two-byte packet ahead of req0
        do_reset();
        push(1, 1'b0, 8'hA1);
        push(1, 1'b1, 8'hA2);
        drive();
        tick();
        push(0, 1'b1, 8'h55);
        drive();
        wait_log("lock_wait", 3, 400);
        check("lock_d0",  log_d(0), 32'hA1);
        check("lock_d1",  log_d(1), 32'hA2);
        check("lock_d2",  log_d(2), 32'h55);
        check("lock_id0", log_i(0), 32'h1);
        check("lock_id1", log_i(1), 32'h1);
        check("lock_id2", log_i(2), 32'h0);
        check("lock_gap", 32'(log_c(1) - log_c(0)), 32'(tx_len + 4));

        // Lock timeout: req2 leaves its packet open, req3 waits
        do_reset();
        push(2, 1'b0, 8'h7E);
        push(3, 1'b1, 8'h33);
        drive();
        wait_log("lto_wait", 2, 400);
        check("lto_d0",      log_d(0), 32'h7E);
        check("lto_id0",     log_i(0), 32'h2);
        check("lto_d1",      log_d(1), 32'h33);
        check("lto_id1",     log_i(1), 32'h3);
        check("lto_release", 32'(ga_fall_cyc - busy_fall_cyc), 32'd16);
        check("lto_gap",     32'(log_c(1) - log_c(0)), 32'(tx_len + 19));
        check("lto_noerr",   32'(err_cnt), 32'h0);

        // Busy timeout: TX core never acknowledges
        do_reset();
        tx_mute = 1'b1;
        push(0, 1'b1, 8'h99);
        drive();
        b = 50;
        while (err_cnt == 0 && b > 0) begin
            tick();
            b--;
        end
        check("bto_seen",    32'(err_cnt), 32'h1);
        check("bto_d0",      log_d(0), 32'h99);
        check("bto_delay",   32'(err_cyc - log_c(0)), 32'd8);
        check("bto_release", 32'(ga_fall_cyc), 32'(err_cyc));
        tick();
        tick();
        tick();
        check("bto_once",    32'(err_cnt), 32'h1);
        tx_mute = 1'b0;
        push(1, 1'b1, 8'h5A);
        drive();
        wait_log("bto_next_wait", 2, 100);
        check("bto_next_id", log_i(1), 32'h1);
        check("bto_next_d",  log_d(1), 32'h5A);
        check("bto_err_end", 32'(err_cnt), 32'h1);

        // Reset in the middle of a locked packet
        do_reset();
        push(1, 1'b0, 8'hC1);
        push(1, 1'b1, 8'hC2);
        drive();
        wait_log("mrst_wait", 1, 50);
        for (int k = 0; k < 5; k++) tick();
        check("mrst_pre_gact", 32'(grant_active), 32'h1);
        rst = 1'b0;
        clear_reqs();
        tick();
        check("mrst_ready", 32'(req_ready),    32'h0);
        check("mrst_start", 32'(tx_start),     32'h0);
        check("mrst_data",  32'(tx_data),      32'h0);
        check("mrst_gid",   32'(grant_id),     32'h0);
        check("mrst_gact",  32'(grant_active), 32'h0);
        check("mrst_err",   32'(err_timeout),  32'h0);
        rst = 1'b1;
        clear_logs();
        push(0, 1'b1, 8'hD0);
        push(1, 1'b1, 8'hD1);
        push(3, 1'b1, 8'hD3);
        drive();
        wait_log("mrst_after_wait", 1, 50);
        check("mrst_first_id", log_i(0), 32'h0);
        check("mrst_first_d",  log_d(0), 32'hD0);

        check("onehot_ready", 32'(onehot_bad), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
